// File: rtl/effect_pkg.sv
// effect_pkg: shared definitions for the effect sequencer.
//   - state_e     : sequencer FSM states
//   - op_class_e  : opcode class held in opcode bits [3:2]
//   - OP_RESET    : system opcode that clears the show and restarts at slot 0
//   - CODE_NOP    : low-bit code treated as a no-op in every class
//   - MOVE_*      : one-hot move encodings {fog, jaw, hands}
//   - op_class()  : opcode -> class
//   - move_bit()  : movement code -> one-hot move pattern
//   - max_int()   : elaboration-time maximum, used for the shared timer width
package effect_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC     = 3'd2,
      ST_SND_WAIT = 3'd3,
      ST_DWELL    = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CLS_SYS   = 2'b00,
      CLS_COLOR = 2'b01,
      CLS_SOUND = 2'b10,
      CLS_MOVE  = 2'b11
   } op_class_e;

   localparam int         NUM_SLOTS  = 4;
   localparam logic [3:0] OP_RESET   = 4'b0001;
   localparam logic [1:0] CODE_NOP   = 2'b11;
   localparam logic [2:0] MOVE_HANDS = 3'b001;
   localparam logic [2:0] MOVE_JAW   = 3'b010;
   localparam logic [2:0] MOVE_FOG   = 3'b100;

   function automatic op_class_e op_class(input logic [3:0] op);
      return op_class_e'(op[3:2]);
   endfunction

   // Movement codes: 00 hands, 01 jaw, 10 fog, 11 nothing.
   function automatic logic [2:0] move_bit(input logic [1:0] code);
      logic [2:0] m;
      case (code)
         2'b00:   m = MOVE_HANDS;
         2'b01:   m = MOVE_JAW;
         2'b10:   m = MOVE_FOG;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter shared by the dwell hold and the
// sound-acknowledge timeout.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   zero     : count is zero
module seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: the default assignment first means every path writes cnt_d, so no latch is inferred.
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: non-blocking assignment so every flop samples the pre-edge value of its inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/effect_sequencer.sv
// effect_sequencer: runs a 4-slot program of 4-bit effect opcodes (colors,
// sounds, movements) with a programmable hold per step.
//   clk, rst     : clock (rising edge) and asynchronous active-high reset
//   enable       : run request
//   prog_we/addr/data : program slot write port
//   dwell        : hold cycles per step minus one, sampled on DWELL entry
//   snd_ack      : sound unit accepted the request (only seen in SND_WAIT)
//   pc           : slot currently executing
//   busy         : FSM is not in IDLE
//   color/color_on : active color and its enable
//   snd_req/snd_code : sound request (held until ack or timeout) and code
//   move         : one-hot {fog, jaw, hands}, asserted only while dwelling
//   snd_timeout  : one-cycle pulse when the ack wait expires
// Every output is a flop; the effect of an opcode is visible the cycle
// after EXEC.
module effect_sequencer
   import effect_pkg::*;
#(
   parameter int DWELL_W     = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               prog_we,
   input  logic [1:0]         prog_addr,
   input  logic [3:0]         prog_data,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               snd_ack,
   output logic [1:0]         pc,
   output logic               busy,
   output logic [1:0]         color,
   output logic               color_on,
   output logic               snd_req,
   output logic [1:0]         snd_code,
   output logic [2:0]         move,
   output logic               snd_timeout
);

   // One counter serves both the dwell hold and the ack timeout.
   localparam int TMR_W = max_int(DWELL_W, $clog2(ACK_TIMEOUT + 1));

   state_e                      state_q, state_d;
   logic [NUM_SLOTS-1:0][3:0]   slot_q, slot_d;
   logic [3:0]                  op_q, op_d;
   logic [1:0]                  pc_q, pc_d;
   logic                        busy_q, busy_d;
   logic [1:0]                  color_q, color_d;
   logic                        color_on_q, color_on_d;
   logic                        snd_req_q, snd_req_d;
   logic [1:0]                  snd_code_q, snd_code_d;
   logic [2:0]                  move_q, move_d;
   logic                        snd_timeout_q, snd_timeout_d;
   // Set by a RESET step so the following DWELL exit leaves pc at 0.
   logic                        reset_step_q, reset_step_d;

   logic                        tmr_load;
   logic [TMR_W-1:0]            tmr_val;
   logic                        tmr_dec;
   logic                        tmr_zero;

   seq_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      op_d          = op_q;
      pc_d          = pc_q;
      color_d       = color_q;
      color_on_d    = color_on_q;
      snd_req_d     = snd_req_q;
      snd_code_d    = snd_code_q;
      move_d        = move_q;
      snd_timeout_d = 1'b0;
      reset_step_d  = reset_step_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      tmr_dec       = 1'b0;

      // The store is a plain register file, so a fetch in the same cycle
      // as a write to that slot still sees the old opcode.
      if (prog_we) begin
         slot_d[prog_addr] = prog_data;
      end

      case (state_q)
         ST_IDLE: begin
            // An all-zero program has nothing to show, so stay idle.
            if (enable && (slot_q != '0)) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            op_d    = slot_q[pc_q];
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            state_d  = ST_DWELL;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(dwell);
            case (op_class(op_q))
               CLS_SYS: begin
                  if (op_q == OP_RESET) begin
                     color_d      = 2'b00;
                     color_on_d   = 1'b0;
                     move_d       = 3'b000;
                     pc_d         = 2'd0;
                     reset_step_d = 1'b1;
                  end
               end
               CLS_COLOR: begin
                  if (op_q[1:0] != CODE_NOP) begin
                     color_d    = op_q[1:0];
                     color_on_d = 1'b1;
                  end
               end
               CLS_SOUND: begin
                  if (op_q[1:0] != CODE_NOP) begin
                     snd_code_d = op_q[1:0];
                     snd_req_d  = 1'b1;
                     state_d    = ST_SND_WAIT;
                     // Counts ACK_TIMEOUT cycles in SND_WAIT, ending at zero.
                     tmr_val    = TMR_W'(ACK_TIMEOUT - 1);
                  end
               end
               default: begin
                  move_d = move_bit(op_q[1:0]);
               end
            endcase
         end

         ST_SND_WAIT: begin
            if (snd_ack) begin
               snd_req_d = 1'b0;
               state_d   = ST_DWELL;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(dwell);
            end else if (tmr_zero) begin
               snd_req_d     = 1'b0;
               snd_timeout_d = 1'b1;
               state_d       = ST_DWELL;
               tmr_load      = 1'b1;
               tmr_val       = TMR_W'(dwell);
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_DWELL: begin
            if (tmr_zero) begin
               move_d       = 3'b000;
               reset_step_d = 1'b0;
               if (!reset_step_q) begin
                  pc_d = pc_q + 2'd1;
               end
               if (enable) begin
                  state_d = ST_FETCH;
               end else begin
                  // Run request withdrawn: the step has finished, so
                  // blank the show and rewind.
                  state_d    = ST_IDLE;
                  pc_d       = 2'd0;
                  color_d    = 2'b00;
                  color_on_d = 1'b0;
                  snd_req_d  = 1'b0;
                  snd_code_d = 2'b00;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         // NOTE: the program store is reset on purpose: an all-zero program is the defined "nothing to run" condition.
         slot_q        <= '0;
         op_q          <= 4'b0000;
         pc_q          <= 2'd0;
         busy_q        <= 1'b0;
         color_q       <= 2'b00;
         color_on_q    <= 1'b0;
         snd_req_q     <= 1'b0;
         snd_code_q    <= 2'b00;
         move_q        <= 3'b000;
         snd_timeout_q <= 1'b0;
         reset_step_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         op_q          <= op_d;
         pc_q          <= pc_d;
         busy_q        <= busy_d;
         color_q       <= color_d;
         color_on_q    <= color_on_d;
         snd_req_q     <= snd_req_d;
         snd_code_q    <= snd_code_d;
         move_q        <= move_d;
         snd_timeout_q <= snd_timeout_d;
         reset_step_q  <= reset_step_d;
      end
   end

   assign pc          = pc_q;
   assign busy        = busy_q;
   assign color       = color_q;
   assign color_on    = color_on_q;
   assign snd_req     = snd_req_q;
   assign snd_code    = snd_code_q;
   assign move        = move_q;
   assign snd_timeout = snd_timeout_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// tb_effect_sequencer: directed scenarios for effect_sequencer. Expected
// per-cycle traces are pushed to a scoreboard when a scenario is started
// and popped as the DUT outputs are sampled on the falling clock edge.
module tb_effect_sequencer;

   localparam int DWELL_W     = 4;
   localparam int ACK_TIMEOUT = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable = 1'b0;
   logic               prog_we = 1'b0;
   logic [1:0]         prog_addr = 2'd0;
   logic [3:0]         prog_data = 4'd0;
   logic [DWELL_W-1:0] dwell = '0;
   logic               snd_ack = 1'b0;
   logic [1:0]         pc;
   logic               busy;
   logic [1:0]         color;
   logic               color_on;
   logic               snd_req;
   logic [1:0]         snd_code;
   logic [2:0]         move;
   logic               snd_timeout;

   int n_assert = 0;
   int n_fail   = 0;

   string       tag_q[$];
   logic [15:0] exp_q[$];

   effect_sequencer #(
      .DWELL_W     (DWELL_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .dwell       (dwell),
      .snd_ack     (snd_ack),
      .pc          (pc),
      .busy        (busy),
      .color       (color),
      .color_on    (color_on),
      .snd_req     (snd_req),
      .snd_code    (snd_code),
      .move        (move),
      .snd_timeout (snd_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] all_outs();
      return {3'b000, pc, busy, color, color_on, snd_req, snd_code, move, snd_timeout};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [15:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic compare_next(input logic [15:0] obs);
      n_assert++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_underflow: observed %h with no expected entry", obs);
      end
      if (exp_q.size() > 0) begin
         check(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   task automatic check_drained(input string tag);
      check(tag, 16'(exp_q.size()), 16'd0);
      tag_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      enable  = 1'b0;
      prog_we = 1'b0;
      snd_ack = 1'b0;
      dwell   = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic write_slot(input logic [1:0] a, input logic [3:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
   endtask

   task automatic load_program(input logic [3:0] s0, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] s3);
      write_slot(2'd0, s0);
      write_slot(2'd1, s1);
      write_slot(2'd2, s2);
      write_slot(2'd3, s3);
   endtask

   // Bounded wait for IDLE, then every output must be back at zero.
   task automatic wait_idle(input string tag);
      int i;
      i = 0;
      @(negedge clk);
      while (busy && (i < 40)) begin
         @(negedge clk);
         i++;
      end
      check(tag, all_outs(), 16'h0000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          st;
      int          ph;
      int          k;
      logic [1:0]  epc;
      logic        eon;
      logic [1:0]  ecol;
      logic        ereq;
      logic        eto;

      // ---------------- reset state ----------------
      rst = 1'b1;
      #2;
      check("reset_during", all_outs(), 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_after", all_outs(), 16'h0000);

      // All-zero program with enable high must not start.
      enable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("zero_prog_idle", {15'b0, busy}, 16'h0000);
      enable = 1'b0;

      // ---------------- A: all fog, dwell 2 ----------------
      do_reset();
      load_program(4'b1110, 4'b1110, 4'b1110, 4'b1110);
      dwell  = 4'd2;
      enable = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         st = (c - 1) / 5;
         ph = (c - 1) % 5;
         push_exp("A_busy_pc_move", {10'b0, 1'b1, 2'(st % 4), (ph >= 2) ? 3'b100 : 3'b000});
      end
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         compare_next({10'b0, busy, pc, move});
      end
      check_drained("A_drained");
      @(posedge clk);
      #1;
      enable = 1'b0;
      wait_idle("A_idle");

      // ---------------- B: colors, no-op hold, same-cycle write ----------------
      do_reset();
      load_program(4'b0100, 4'b0110, 4'b0000, 4'b0000);
      dwell  = 4'd0;
      enable = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         eon  = (c >= 3);
         ecol = (c >= 6) ? 2'b10 : 2'b00;
         epc  = 2'((c - 1) / 3);
         push_exp("B_on_color_pc", {11'b0, eon, ecol, epc});
      end
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         // Overwrite slot 1 during its own FETCH: the old opcode must run.
         prog_we   = (c == 4);
         prog_addr = 2'd1;
         prog_data = 4'b0101;
         @(negedge clk);
         compare_next({11'b0, color_on, color, pc});
      end
      check_drained("B_drained");
      @(posedge clk);
      #1;
      prog_we = 1'b0;
      enable  = 1'b0;
      wait_idle("B_idle");

      // ---------------- C: boo, ack 3 cycles after request ----------------
      do_reset();
      load_program(4'b1010, 4'b0000, 4'b0000, 4'b0000);
      dwell  = 4'd0;
      enable = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         ereq = (c >= 3) && (c <= 6);
         push_exp("C_req_to_busy_code", {11'b0, ereq, 1'b0, 1'b1, ereq ? 2'b10 : 2'b00});
      end
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         // The ack in cycle 2 arrives during EXEC and must be ignored.
         snd_ack = (c == 2) || (c == 6);
         @(negedge clk);
         compare_next({11'b0, snd_req, snd_timeout, busy, snd_req ? snd_code : 2'b00});
      end
      check_drained("C_drained");
      @(posedge clk);
      #1;
      snd_ack = 1'b0;
      enable  = 1'b0;
      wait_idle("C_idle");

      // ---------------- D: scream, no ack -> timeout ----------------
      do_reset();
      load_program(4'b1000, 4'b0000, 4'b0000, 4'b0000);
      dwell  = 4'd0;
      enable = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         ereq = (c >= 3) && (c <= 2 + ACK_TIMEOUT);
         eto  = (c == 3 + ACK_TIMEOUT);
         push_exp("D_req_timeout", {14'b0, ereq, eto});
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         compare_next({14'b0, snd_req, snd_timeout});
      end
      check_drained("D_drained");
      @(posedge clk);
      #1;
      enable = 1'b0;
      wait_idle("D_idle");

      // ---------------- E: RESET opcode loops slots 0..1 ----------------
      do_reset();
      load_program(4'b0101, 4'b0001, 4'b1100, 4'b1100);
      dwell  = 4'd0;
      enable = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         k   = (c - 1) % 6;
         epc = ((k == 3) || (k == 4)) ? 2'd1 : 2'd0;
         eon = (k >= 2) && (k <= 4);
         push_exp("E_on_pc_move", {10'b0, eon, epc, 3'b000});
      end
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         compare_next({10'b0, color_on, pc, move});
      end
      check_drained("E_drained");
      @(posedge clk);
      #1;
      enable = 1'b0;
      wait_idle("E_idle");

      // ---------------- F1: rst during SND_WAIT ----------------
      do_reset();
      load_program(4'b1000, 4'b0000, 4'b0000, 4'b0000);
      dwell  = 4'd0;
      enable = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("F1_in_snd_wait", {15'b0, snd_req}, 16'h0001);
      #2;
      rst = 1'b1;
      #1;
      check("F1_rst_async", all_outs(), 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Enable is still high, but reset cleared the program.
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("F1_after_rst", {14'b0, busy, snd_req}, 16'h0000);
      end
      enable = 1'b0;

      // ---------------- F2: enable drops mid-DWELL ----------------
      do_reset();
      load_program(4'b1101, 4'b1101, 4'b1101, 4'b1101);
      dwell  = 4'd2;
      enable = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c <= 5) begin
            push_exp("F2_busy_pc_move", {10'b0, 1'b1, 2'd0, (c >= 3) ? 3'b010 : 3'b000});
         end else if (c <= 10) begin
            push_exp("F2_busy_pc_move", {10'b0, 1'b1, 2'd1, (c >= 8) ? 3'b010 : 3'b000});
         end else begin
            push_exp("F2_busy_pc_move", 16'h0000);
         end
      end
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (c == 9) begin
            // Step must still finish its full 3-cycle dwell sampled at entry.
            enable = 1'b0;
            dwell  = 4'd0;
         end
         @(negedge clk);
         compare_next({10'b0, busy, pc, move});
      end
      check_drained("F2_drained");
      check("F2_idle_outputs", all_outs(), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/effect_sequencer.md
EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 4: width of the dwell input.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: maximum cycles to wait for snd_ack.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1: run request; high = execute the program.
REQ-006 SHALL have port prog_we, input, 1: program slot write strobe.
REQ-007 SHALL have port prog_addr, input, 2: slot index 0..3.
REQ-008 SHALL have port prog_data, input, 4: opcode to write.
REQ-009 SHALL have port dwell, input, DWELL_W: hold cycles per step minus one.
REQ-010 SHALL have port snd_ack, input, 1: sound unit accepted request.
REQ-011 SHALL have port pc, output, 2: slot currently executing.
REQ-012 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-013 SHALL have port color, output, 2: 00 green, 01 purple, 10 orange.
REQ-014 SHALL have port color_on, output, 1: a color is active.
REQ-015 SHALL have port snd_req, output, 1: sound request, held until acknowledged.
REQ-016 SHALL have port snd_code, output, 2: 00 scream, 01 cackle, 10 boo.
REQ-017 SHALL have port move, output, 3: one-hot {fog, jaw, hands}.
REQ-018 SHALL have port snd_timeout, output, 1: one-cycle pulse on ack timeout.

Function
REQ-019 Program store SHALL be 4 x 4-bit registers; a write takes effect the cycle after prog_we, and a same-cycle fetch of that slot SHALL return the old value.
REQ-020 Opcode classes SHALL be: [3:2]=00 system, 01 color, 10 sound, 11 movement.
REQ-021 FSM states SHALL be IDLE, FETCH, EXEC, SND_WAIT, DWELL.
REQ-022 IDLE -> FETCH SHALL occur when enable=1 and at least one slot is nonzero; an all-zero program SHALL keep the FSM in IDLE.
REQ-023 FETCH (1 cycle) SHALL latch slot[pc]; EXEC (1 cycle) SHALL decode it; outputs SHALL be registered and SHALL become visible in the cycle after EXEC.
REQ-024 0000 (ON) SHALL be a no-op step; 0001 (RESET) SHALL clear color_on and move, set pc to 0, and enter DWELL without incrementing pc.
REQ-025 Codes 0010, 0011, 0111, 1011, 1111 SHALL be no-op steps.
REQ-026 Color opcodes SHALL update color and set color_on; color SHALL persist across steps until changed, cleared by RESET, or the FSM returns to IDLE.
REQ-027 Sound opcodes SHALL drive snd_code and snd_req and enter SND_WAIT.
REQ-028 In SND_WAIT, snd_ack=1 SHALL drop snd_req the next cycle and enter DWELL.
REQ-029 After ACK_TIMEOUT cycles in SND_WAIT with no ack, the block SHALL drop snd_req, pulse snd_timeout, and enter DWELL.
REQ-030 Movement opcodes SHALL assert the matching move bit for exactly the DWELL cycles of that step.
REQ-031 A movement opcode with code 11 SHALL be treated as a no-op.
REQ-032 DWELL SHALL last dwell+1 cycles; the dwell value SHALL be sampled on DWELL entry.
REQ-033 On DWELL exit, move SHALL clear and pc SHALL increment, wrapping 3 -> 0, except after RESET.
REQ-034 If enable=0 on DWELL exit, the FSM SHALL enter IDLE, clear all outputs and set pc to 0; the current step SHALL always complete.
REQ-035 snd_ack outside SND_WAIT SHALL be ignored.

Reset
REQ-036 rst SHALL force IDLE with pc=0, all slots=0000, color=00, color_on=0, snd_req=0, snd_code=00, move=000, snd_timeout=0, busy=0 and all counters at 0.
REQ-037 rst asserted mid-step, including during SND_WAIT, SHALL abort immediately with no further snd_req.

Structure
REQ-038 A shared package effect_pkg SHALL hold the opcode constants, class encodings and the state enum.
REQ-039 The dwell/timeout down-counter SHALL be one sub-module, seq_timer, reused for both counts.

Verification
REQ-040 Program all slots 1110, dwell=2, enable=1: move=100 for 3 of every 5 cycles, and pc steps 0,1,2,3,0.
REQ-041 Program {0100,0110,0000,0000}, dwell=0: color=00 then color=10; color_on stays 1 through the no-op slots.
REQ-042 Slot0=1010 with snd_ack 3 cycles after snd_req rises: snd_code=10, snd_req high 4 cycles, then DWELL.
REQ-043 Slot0=1000 with no ack, ACK_TIMEOUT=15: snd_req drops after 15 cycles and snd_timeout pulses once.
REQ-044 Program {0101,0001,1100,1100}: after the RESET step color_on=0, pc returns to 0, and slots 2 and 3 never execute.
REQ-045 rst during SND_WAIT, and enable=0 mid-DWELL: rst gives immediate IDLE with outputs 0; enable=0 gives IDLE after the step finishes.
